// File: rtl/display_scanner.sv
// display_scanner: time-multiplexed seven-segment driver with tear-free shadow capture and PWM brightness
module display_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int BRIGHT_W   = 4,
  parameter int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  input  logic [BRIGHT_W-1:0]     brightness,
  input  logic                    load,
  output logic                    busy,
  output logic                    load_ack,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_start
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_DIGITS - 1);

  logic [BRIGHT_W-1:0]     tick_q, tick_d;
  logic [IDX_W-1:0]        dig_q, dig_d;
  logic                    busy_q, busy_d, ack_q, ack_d, capture, wrap;
  logic [4*NUM_DIGITS-1:0] val_q, val_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d, en_q, en_d;
  logic                    blank_q, blank_d;
  logic [BRIGHT_W-1:0]     bright_q, bright_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d, blanked;
  logic [6:0]              seg_q, seg_d;
  logic                    dpn_q, dpn_d, fs_q, fs_d, lit, dp_cur, zero_run;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [3:0]              nib;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // Scan counters and load handshake; shadows only change on the last tick of the last digit
  always_comb begin
    wrap     = &tick_q;
    tick_d   = tick_q + 1'b1;
    dig_d    = wrap ? ((dig_q == LAST) ? '0 : dig_q + 1'b1) : dig_q;
    capture  = busy_q & wrap & (dig_q == LAST);
    busy_d   = capture ? 1'b0 : (busy_q | load);
    ack_d    = capture;
    val_d    = capture ? value : val_q;
    dp_d     = capture ? dp : dp_q;
    en_d     = capture ? digit_en : en_q;
    blank_d  = capture ? blank_lz : blank_q;
    bright_d = capture ? brightness : bright_q;
  end

  // Digit output: blanking runs from the most significant digit down, stopping at the first nonzero nibble or dp
  always_comb begin
    blanked  = '0;
    zero_run = 1'b1;
    nib      = 4'h0;
    dp_cur   = 1'b0;
    lit      = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run & (val_q[4*i +: 4] == 4'h0) & ~dp_q[i];
      blanked[i] = (i != 0) & blank_q & zero_run;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_q == IDX_W'(i)) begin
        nib    = val_q[4*i +: 4];
        dp_cur = dp_q[i];
        lit    = en_q[i] & ~blanked[i] & (tick_q <= bright_q);
      end
    end
    anode_d = lit ? ~(NUM_DIGITS'(1) << dig_q) : '1;
    seg_d   = lit ? ~hex7(nib) : 7'h7F;
    dpn_d   = ~(lit & dp_cur);
    idx_d   = dig_q;
    fs_d    = (dig_q == '0) & (tick_q == '0);
  end

  // State and registered outputs; reset leaves the display dark and drops any pending load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q   <= '0;
      dig_q    <= '0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      val_q    <= '0;
      dp_q     <= '0;
      en_q     <= '0;
      blank_q  <= 1'b0;
      bright_q <= '0;
      anode_q  <= '1;
      seg_q    <= 7'h7F;
      dpn_q    <= 1'b1;
      idx_q    <= '0;
      fs_q     <= 1'b0;
    end else begin
      tick_q   <= tick_d;
      dig_q    <= dig_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      val_q    <= val_d;
      dp_q     <= dp_d;
      en_q     <= en_d;
      blank_q  <= blank_d;
      bright_q <= bright_d;
      anode_q  <= anode_d;
      seg_q    <= seg_d;
      dpn_q    <= dpn_d;
      idx_q    <= idx_d;
      fs_q     <= fs_d;
    end
  end

  assign busy        = busy_q;
  assign load_ack    = ack_q;
  assign anode       = anode_q;
  assign seg         = seg_q;
  assign dp_n        = dpn_q;
  assign digit_idx   = idx_q;
  assign frame_start = fs_q;
endmodule
